writeback_select: RTL and testbench
===================================

// Module: writeback_select
// PURPOSE
//  Write-back end of the datapath: picks the register-file write value (ALU result,
//  load data, PC+4 or immediate), aligns/extends load data, and issues one registered
//  write per accepted instruction. Sits after the data-memory stage, feeding the
//  register file. A small FSM stalls the upstream stage while a load waits on memory.
// PARAMETERS
//  XLEN         32  datapath width; only 32 supported
//  MEM_TIMEOUT  15  max cycles in WAIT_MEM before the load is aborted
// PORTS
//  clock        in   1     single clock; all state updates on posedge
//  reset        in   1     asynchronous, active-high
//  inValid      in   1     upstream presents an instruction
//  inReady      out  1     block can accept (accept = inValid & inReady)
//  memToReg     in   2     00 ALU, 01 load, 10 PC+4, 11 immediate
//  funct3       in   3     load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  aluResult    in   XLEN  ALU result; also the load byte address
//  pcPlus4      in   XLEN  return address for JAL/JALR
//  imm          in   XLEN  immediate (LUI)
//  rdIn         in   5     destination register
//  regWriteIn   in   1     instruction writes a register
//  memReady     in   1     memReadData valid this cycle
//  memReadData  in   XLEN  aligned 32-bit memory word
//  regWrite     out  1     one-cycle write strobe to register file
//  rd           out  5     registered destination
//  writeData    out  XLEN  registered write value
//  memError     out  1     one-cycle pulse: misaligned load or timeout
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0, regWrite/memError 0, rd 0, writeData 0.
//    Reset mid-WAIT_MEM drops the pending load; no write is issued.
//  - inReady = 1 in IDLE, 0 in WAIT_MEM (combinational from state).
//  - IDLE, accept, memToReg != 01: next cycle regWrite=regWriteIn&(rdIn!=0),
//    rd=rdIn, writeData=selected source. Latency 1.
//  - IDLE, accept, memToReg == 01 and memReady=1 same cycle: commit next cycle as above.
//  - IDLE, accept, load, memReady=0: capture rdIn, regWriteIn, funct3, aluResult[1:0];
//    go WAIT_MEM, counter cleared.
//  - WAIT_MEM: counter increments each cycle memReady=0. memReady=1 -> commit next
//    cycle from captured fields, go IDLE. Counter reaches MEM_TIMEOUT with no memReady
//    -> memError pulse next cycle, regWrite 0, go IDLE. memReady on the timeout cycle wins.
//  - Load extraction, off=aluResult[1:0]: LB/LBU byte off, sign/zero-extend; LH/LHU
//    half at off[1], sign/zero-extend; LW whole word.
//  - Misaligned (LH/LHU off[0]=1; LW off!=0) or illegal funct3 (011,11x): no write,
//    memError pulse at the commit cycle instead.
//  - regWrite and memError are never high together; both default 0 when nothing commits.
//  - rd=0 never asserts regWrite; writeData/rd still update.
//  - writeData and rd hold their last values when no commit occurs.
// STRUCTURE
//  - wb_pkg: MEM_TO_REG_{ALU,LOAD,PC4,IMM} codes, F3_{LB,LH,LW,LBU,LHU} constants,
//    state enum {IDLE, WAIT_MEM}.
//  - Sub-module load_extract (combinational): funct3, offset, word -> value, misaligned.
//  - Top: FSM, timeout counter, capture registers, source mux, output registers.
// TESTING
//  - ALU path: memToReg=00, aluResult=0x0000_1234, rdIn=5 -> next cycle regWrite=1,
//    rd=5, writeData=0x0000_1234.
//  - LB sign: memToReg=01, funct3=000, aluResult=...03, memReady=1, word=0x80FF_0000
//    -> writeData=0xFFFF_FF80; same with LBU -> 0x0000_0080.
//  - Load stall: memReady low 3 cycles -> inReady=0 three cycles, then LHU off=2,
//    word=0xBEEF_0000 -> writeData=0x0000_BEEF, inReady back to 1.
//  - Timeout: memReady never high -> memError single pulse after MEM_TIMEOUT cycles,
//    no regWrite, FSM returns IDLE.
//  - Misaligned LW at aluResult=...01 -> memError pulse, regWrite 0; rdIn=0 JAL
//    (memToReg=10) -> regWrite 0.
//  - Reset asserted in WAIT_MEM -> all outputs 0 immediately, later memReady ignored.

Source files
------------

// File: rtl/writeback_select_pkg.sv
// Shared encodings for the write-back stage: source selects, load types, FSM states.
package wb_pkg;

   localparam logic [1:0] MEM_TO_REG_ALU  = 2'b00;
   localparam logic [1:0] MEM_TO_REG_LOAD = 2'b01;
   localparam logic [1:0] MEM_TO_REG_PC4  = 2'b10;
   localparam logic [1:0] MEM_TO_REG_IMM  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE,
      WAIT_MEM
   } wb_state_e;

endpackage

// File: rtl/writeback_select_if.sv
// Upstream/memory-facing bundle of the write-back stage plus its register-file outputs.
interface writeback_select_if #(
   parameter int XLEN = 32
);
   logic            inValid;
   logic            inReady;
   logic [1:0]      memToReg;
   logic [2:0]      funct3;
   logic [XLEN-1:0] aluResult;
   logic [XLEN-1:0] pcPlus4;
   logic [XLEN-1:0] imm;
   logic [4:0]      rdIn;
   logic            regWriteIn;
   logic            memReady;
   logic [XLEN-1:0] memReadData;
   logic            regWrite;
   logic [4:0]      rd;
   logic [XLEN-1:0] writeData;
   logic            memError;

   modport master (
      output inValid, memToReg, funct3, aluResult, pcPlus4, imm, rdIn, regWriteIn,
             memReady, memReadData,
      input  inReady, regWrite, rd, writeData, memError
   );

   modport slave (
      input  inValid, memToReg, funct3, aluResult, pcPlus4, imm, rdIn, regWriteIn,
             memReady, memReadData,
      output inReady, regWrite, rd, writeData, memError
   );
endinterface

// File: rtl/writeback_select_load_extract.sv
// Picks the addressed byte/half/word out of an aligned memory word and extends it;
// flags misaligned accesses and unsupported load types.
module load_extract
   import wb_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_word,
   output logic [31:0] o_value,
   output logic        o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_offset)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
   end

   always_comb begin
      o_value      = '0;
      o_misaligned = 1'b0;
      case (i_funct3)
         F3_LB:  o_value = {{24{w_byte[7]}}, w_byte};
         F3_LBU: o_value = {24'h0, w_byte};
         F3_LH: begin
            o_value      = {{16{w_half[15]}}, w_half};
            o_misaligned = i_offset[0];
         end
         F3_LHU: begin
            o_value      = {16'h0, w_half};
            o_misaligned = i_offset[0];
         end
         F3_LW: begin
            o_value      = i_word;
            o_misaligned = (i_offset != 2'd0);
         end
         default: o_misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_select.sv
// Write-back stage: selects the register-file value, stalls upstream while a load
// waits on memory, and issues one registered write (or error pulse) per instruction.
module writeback_select
   import wb_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input logic               clock,
   input logic               reset,
   writeback_select_if.slave bus
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   wb_state_e       r_state;
   logic [CW-1:0]   r_cnt;
   logic [4:0]      r_rd_cap;
   logic            r_we_cap;
   logic [2:0]      r_f3_cap;
   logic [1:0]      r_off_cap;
   logic            r_regWrite;
   logic            r_memError;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_writeData;

   logic            w_idle;
   logic            w_accept;
   logic            w_is_load;
   logic [2:0]      w_f3;
   logic [1:0]      w_off;
   logic [4:0]      w_rd;
   logic            w_we;
   logic [31:0]     w_load_val;
   logic            w_load_err;
   logic [XLEN-1:0] w_src;

   assign w_idle    = (r_state == IDLE);
   assign w_accept  = bus.inValid & w_idle;
   assign w_is_load = (bus.memToReg == MEM_TO_REG_LOAD);

   // In IDLE a same-cycle load uses the live fields; in WAIT_MEM the captured ones.
   assign w_f3  = w_idle ? bus.funct3         : r_f3_cap;
   assign w_off = w_idle ? bus.aluResult[1:0] : r_off_cap;
   assign w_rd  = w_idle ? bus.rdIn           : r_rd_cap;
   assign w_we  = w_idle ? bus.regWriteIn     : r_we_cap;

   load_extract u_load_extract (
      .i_funct3     (w_f3),
      .i_offset     (w_off),
      .i_word       (bus.memReadData),
      .o_value      (w_load_val),
      .o_misaligned (w_load_err)
   );

   always_comb begin
      case (bus.memToReg)
         MEM_TO_REG_ALU: w_src = bus.aluResult;
         MEM_TO_REG_PC4: w_src = bus.pcPlus4;
         MEM_TO_REG_IMM: w_src = bus.imm;
         default:        w_src = w_load_val;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rd_cap    <= '0;
         r_we_cap    <= 1'b0;
         r_f3_cap    <= '0;
         r_off_cap   <= '0;
         r_regWrite  <= 1'b0;
         r_memError  <= 1'b0;
         r_rd        <= '0;
         r_writeData <= '0;
      end else begin
         r_regWrite <= 1'b0;
         r_memError <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_is_load && !bus.memReady) begin
                     r_rd_cap  <= bus.rdIn;
                     r_we_cap  <= bus.regWriteIn;
                     r_f3_cap  <= bus.funct3;
                     r_off_cap <= bus.aluResult[1:0];
                     r_cnt     <= '0;
                     r_state   <= WAIT_MEM;
                  end else if (w_is_load && w_load_err) begin
                     r_memError <= 1'b1;
                  end else begin
                     r_regWrite  <= w_we & (w_rd != 5'd0);
                     r_rd        <= w_rd;
                     r_writeData <= w_src;
                  end
               end
            end
            WAIT_MEM: begin
               // memReady is checked first so data on the timeout cycle still commits.
               if (bus.memReady) begin
                  r_state <= IDLE;
                  if (w_load_err) begin
                     r_memError <= 1'b1;
                  end else begin
                     r_regWrite  <= w_we & (w_rd != 5'd0);
                     r_rd        <= w_rd;
                     r_writeData <= w_load_val;
                  end
               end else if (r_cnt == CW'(MEM_TIMEOUT - 1)) begin
                  r_memError <= 1'b1;
                  r_state    <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.inReady   = w_idle;
   assign bus.regWrite  = r_regWrite;
   assign bus.memError  = r_memError;
   assign bus.rd        = r_rd;
   assign bus.writeData = r_writeData;

endmodule

// File: tb/tb_writeback_select.sv
// Randomized self-checking bench for writeback_select against a behavioural model.
module tb_writeback_select;
   import wb_pkg::*;

   localparam int TMO = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   writeback_select_if #(.XLEN(32)) bus ();

   writeback_select #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [4:0]  exp_rd   = '0;
   logic [31:0] exp_wd   = '0;

   // Returns {error, value} for a load of type f3 at byte offset off in word w.
   function automatic logic [32:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
      case (f3)
         3'b000:  return {1'b0, (b >= 128) ? b + 32'hFFFF_FF00 : b};
         3'b100:  return {1'b0, b};
         3'b001:  return off[0] ? {1'b1, 32'h0} : {1'b0, (h >= 32768) ? h + 32'hFFFF_0000 : h};
         3'b101:  return off[0] ? {1'b1, 32'h0} : {1'b0, h};
         3'b010:  return (off != 2'd0) ? {1'b1, 32'h0} : {1'b0, w};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   task automatic check_out(input string name, input logic we, input logic err);
      n_checks++;
      if (bus.regWrite !== we || bus.memError !== err || bus.rd !== exp_rd ||
          bus.writeData !== exp_wd || bus.inReady !== 1'b1)
         $display("FAIL %s: got we=%0b err=%0b rd=%0d wd=%h rdy=%0b, want we=%0b err=%0b rd=%0d wd=%h rdy=1",
                  name, bus.regWrite, bus.memError, bus.rd, bus.writeData, bus.inReady,
                  we, err, exp_rd, exp_wd);
      else n_pass++;
   endtask

   // One instruction; delay = cycles memReady stays low starting at the accept cycle.
   task automatic issue(input string name, input logic [1:0] ms, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] immv,
                        input logic [4:0] rdv, input logic we, input int delay,
                        input logic [31:0] word);
      logic [32:0] m;
      logic        e_err, e_we;
      int          nw;
      if (ms == MEM_TO_REG_LOAD) m = model_load(f3, alu[1:0], word);
      else m = {1'b0, (ms == MEM_TO_REG_ALU) ? alu : (ms == MEM_TO_REG_PC4) ? pc4 : immv};
      nw    = (ms == MEM_TO_REG_LOAD) ? ((delay <= TMO) ? delay : TMO) : 0;
      e_err = m[32] || (ms == MEM_TO_REG_LOAD && delay > TMO);
      e_we  = !e_err && we && (rdv != 5'd0);

      bus.inValid = 1'b1; bus.memToReg = ms; bus.funct3 = f3; bus.aluResult = alu;
      bus.pcPlus4 = pc4; bus.imm = immv; bus.rdIn = rdv; bus.regWriteIn = we;
      bus.memReady = (delay == 0);
      bus.memReadData = (delay == 0) ? word : $urandom;
      n_checks++;
      if (bus.inReady !== 1'b1) $display("FAIL %s accept: inReady=%0b want 1", name, bus.inReady);
      else n_pass++;
      @(posedge clk); #1;
      bus.inValid = 1'b0; bus.funct3 = 3'($urandom); bus.aluResult = $urandom;
      bus.rdIn = 5'($urandom); bus.regWriteIn = 1'($urandom);
      for (int k = 1; k <= nw; k++) begin
         n_checks++;
         if (bus.inReady !== 1'b0 || bus.regWrite !== 1'b0 || bus.memError !== 1'b0)
            $display("FAIL %s stall%0d: rdy=%0b we=%0b err=%0b want 0 0 0",
                     name, k, bus.inReady, bus.regWrite, bus.memError);
         else n_pass++;
         bus.memReady = (k == delay);
         bus.memReadData = (k == delay) ? word : $urandom;
         @(posedge clk); #1;
      end
      bus.memReady = 1'b0;
      if (!e_err) begin exp_rd = rdv; exp_wd = m[31:0]; end
      check_out(name, e_we, e_err);
   endtask

   task automatic idle_cycle(input string name);
      bus.inValid = 1'b0;
      bus.memReady = 1'($urandom);
      bus.memReadData = $urandom;
      @(posedge clk); #1;
      bus.memReady = 1'b0;
      check_out(name, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      bus.inValid = 0; bus.memToReg = 0; bus.funct3 = 0; bus.aluResult = 0; bus.pcPlus4 = 0;
      bus.imm = 0; bus.rdIn = 0; bus.regWriteIn = 0; bus.memReady = 0; bus.memReadData = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_rd = '0; exp_wd = '0;
      check_out("reset", 1'b0, 1'b0);
   endtask

   task automatic test_alu();
      issue("alu", MEM_TO_REG_ALU, 3'd0, 32'h0000_1234, 32'h4, 32'h8, 5'd5, 1'b1, 0, 32'h0);
      n_checks++;
      if (bus.writeData !== 32'h0000_1234 || bus.rd !== 5'd5 || bus.regWrite !== 1'b1)
         $display("FAIL alu_direct: wd=%h rd=%0d we=%0b want 00001234 5 1",
                  bus.writeData, bus.rd, bus.regWrite);
      else n_pass++;
   endtask

   task automatic test_load_sign();
      issue("lb", MEM_TO_REG_LOAD, F3_LB, 32'h0000_1003, 0, 0, 5'd7, 1'b1, 0, 32'h80FF_0000);
      n_checks++;
      if (bus.writeData !== 32'hFFFF_FF80) $display("FAIL lb_direct: wd=%h want ffffff80", bus.writeData);
      else n_pass++;
      issue("lbu", MEM_TO_REG_LOAD, F3_LBU, 32'h0000_1003, 0, 0, 5'd7, 1'b1, 0, 32'h80FF_0000);
      n_checks++;
      if (bus.writeData !== 32'h0000_0080) $display("FAIL lbu_direct: wd=%h want 00000080", bus.writeData);
      else n_pass++;
   endtask

   task automatic test_load_stall();
      issue("lhu_stall", MEM_TO_REG_LOAD, F3_LHU, 32'h0000_2002, 0, 0, 5'd9, 1'b1, 3, 32'hBEEF_0000);
      n_checks++;
      if (bus.writeData !== 32'h0000_BEEF) $display("FAIL lhu_direct: wd=%h want 0000beef", bus.writeData);
      else n_pass++;
      issue("ready_at_limit", MEM_TO_REG_LOAD, F3_LW, 32'h10, 0, 0, 5'd3, 1'b1, TMO, 32'hCAFE_F00D);
   endtask

   task automatic test_timeout();
      issue("timeout", MEM_TO_REG_LOAD, F3_LW, 32'h20, 0, 0, 5'd4, 1'b1, TMO + 5, 32'h1);
      idle_cycle("timeout_single_pulse");
   endtask

   task automatic test_misaligned();
      issue("lw_misaligned", MEM_TO_REG_LOAD, F3_LW, 32'h0000_0001, 0, 0, 5'd6, 1'b1, 0, 32'h5555_AAAA);
      idle_cycle("misaligned_single_pulse");
      issue("jal_rd0", MEM_TO_REG_PC4, 3'd0, 32'h0, 32'h0000_0104, 32'h0, 5'd0, 1'b1, 0, 32'h0);
   endtask

   task automatic test_reset_wait();
      bus.inValid = 1'b1; bus.memToReg = MEM_TO_REG_LOAD; bus.funct3 = F3_LW;
      bus.aluResult = 32'h40; bus.rdIn = 5'd12; bus.regWriteIn = 1'b1; bus.memReady = 1'b0;
      @(posedge clk); #1;
      bus.inValid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      exp_rd = '0; exp_wd = '0;
      check_out("reset_in_wait", 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.memReadData = 32'h1234_5678;
      repeat (3) idle_cycle("after_reset_ignore_mem");
   endtask

   task automatic test_random();
      logic [1:0] ms;
      int         d;
      for (int i = 0; i < 150; i++) begin
         ms = 2'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 2, 3: d = 0;
            4, 5, 6:    d = $urandom_range(1, 4);
            default:    d = $urandom_range(TMO - 1, TMO + 2);
         endcase
         issue("random", ms, 3'($urandom), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom), d, $urandom);
         if ($urandom_range(0, 4) == 0) idle_cycle("random_idle");
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_sign();
      test_load_stall();
      test_timeout();
      test_misaligned();
      test_reset_wait();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
